fsm_round_counter: RTL and testbench
====================================

// Module: fsm_round_counter
// PURPOSE
//   Parametrised successor of the single-shot go/count/done controller.
//   Counts 0..term per round, for (repeat_n+1) rounds, then signals done.
//   Adds: programmable terminal, multi-round repeat, abort, and ack-or-pulse done.
//   Sits beside datapath sequencers as their start/complete timing controller.
// PARAMETERS
//   CNT_W      8  width of count and terminal value
//   RPT_W      4  width of repeat count (extra rounds after the first)
//   DONE_PULSE 0  0: DONE held until ack/abort; 1: DONE lasts 1 cycle, then IDLE
// PORTS
//   clk         in   1      single clock, all state on posedge
//   rst         in   1      synchronous, active-high reset
//   go          in   1      start request, sampled only in IDLE
//   abort       in   1      cancel; effective in COUNTING and DONE
//   ack         in   1      clears DONE (DONE_PULSE=0 only; ignored otherwise)
//   term        in   CNT_W  terminal count, latched into term_q on accepted go
//   repeat_n    in   RPT_W  extra rounds, latched into rounds_left on accepted go
//   busy        out  1      state==COUNTING
//   done        out  1      state==DONE
//   count       out  CNT_W  current count
//   rounds_left out  RPT_W  rounds remaining after the current one
//   round_tick  out  1      1-cycle pulse after each non-final round wraps
//   aborted     out  1      1-cycle pulse after an accepted abort
// BEHAVIOUR
//   - Moore FSM, states IDLE, COUNTING, DONE; busy/done decoded from state flops only.
//   - Reset: state=IDLE, count=0, term_q=0, rounds_left=0, round_tick=0, aborted=0.
//     rst overrides every input, including mid-round.
//   - IDLE: go=1 & abort=0 -> COUNTING; count<=0; term_q<=term; rounds_left<=repeat_n.
//     go&abort together -> stay IDLE, no aborted pulse. count holds in IDLE.
//   - COUNTING, priority abort > wrap > increment:
//     abort -> IDLE, count<=0, aborted<=1 next cycle.
//     count==term_q & rounds_left!=0 -> count<=0, rounds_left-=1, round_tick<=1.
//     count==term_q & rounds_left==0 -> DONE, count holds term_q.
//     otherwise count<=count+1, modulo 2^CNT_W, never reached past term_q.
//   - Latency: go accepted at edge E0 -> done visible after edge E0+(term+1)*(repeat_n+1).
//     term=0 gives 1-cycle rounds. term=2^CNT_W-1 must not overflow the compare.
//   - DONE, DONE_PULSE=0: hold until ack or abort -> IDLE. abort here also pulses aborted.
//     go in DONE is ignored, including when go coincides with ack.
//   - DONE, DONE_PULSE=1: unconditional -> IDLE next edge; ack ignored.
//     abort in that cycle -> IDLE with no aborted pulse.
//   - term/repeat_n changes while busy have no effect; only the latched copies are used.
//   - round_tick and aborted are registered, never both high, and low after reset.
//   - Illegal state encoding -> IDLE next edge.
// STRUCTURE
//   - Package fsm_pkg: state_t enum {IDLE=2'b00, COUNTING=2'b01, DONE=2'b10}.
//     Same package also holds DONE_HOLD=0 and DONE_ONESHOT=1 constants for DONE_PULSE.
//   - Sub-module fsm_cnt_core #(W): clear/enable counter with term compare -> at_term.
//     Instantiated once here for count; the top keeps the FSM and the round logic.
// TESTING
//   1. term=3, repeat_n=0, go at E0 -> busy 4 cycles, count 0..3, done after E4,
//      holds until ack, then IDLE.
//   2. term=1, repeat_n=2 -> round_tick after E2 and E4, rounds_left 2->1->0,
//      done after E6.
//   3. term=5, abort while count=2 -> IDLE next edge, count=0, aborted pulses 1 cycle,
//      done never asserts.
//   4. DONE_PULSE=1, term=0, repeat_n=0 -> done high exactly 1 cycle after E1;
//      ack ignored.
//   5. rst during COUNTING (count=4) -> all outputs at reset values next cycle;
//      a later go restarts from 0.
//   6. go+abort together in IDLE -> stays IDLE; go+ack in DONE -> IDLE, no restart;
//      term=8'hFF -> done after 256 cycles.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared types and constants for the round-counter controller.
//   state_t      : controller state encoding (IDLE, COUNTING, DONE)
//   DONE_HOLD    : DONE_PULSE value selecting a held DONE (cleared by ack/abort)
//   DONE_ONESHOT : DONE_PULSE value selecting a single-cycle DONE
package fsm_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      COUNTING = 2'b01,
      DONE     = 2'b10
   } state_t;

   localparam bit DONE_HOLD    = 1'b0;
   localparam bit DONE_ONESHOT = 1'b1;

endpackage

// File: rtl/fsm_cnt_core.sv
// Clear/enable up-counter with a terminal-value compare.
// Ports:
//   clk     in  1  clock, all state on posedge
//   rst     in  1  synchronous active-high reset (count -> 0)
//   clr     in  1  synchronous clear, takes priority over en
//   en      in  1  increment by one (wraps modulo 2^W)
//   term    in  W  terminal value to compare against
//   count   out W  current count
//   at_term out 1  count == term (combinational)
module fsm_cnt_core #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         at_term
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   // Full-width equality, so term = all-ones needs no extra headroom bit.
   assign at_term = (count == term);

endmodule

// File: rtl/fsm_round_counter.sv
// Start/complete timing controller: counts 0..term per round for
// (repeat_n+1) rounds, then signals done. Supports abort and either a held
// (ack-cleared) or single-cycle done.
// Ports:
//   clk         in  1      clock, all state on posedge
//   rst         in  1      synchronous active-high reset
//   go          in  1      start request, sampled only in IDLE
//   abort       in  1      cancel, effective in COUNTING and DONE
//   ack         in  1      clears a held DONE (ignored in one-shot mode)
//   term        in  CNT_W  terminal count, latched on accepted go
//   repeat_n    in  RPT_W  extra rounds, latched on accepted go
//   busy        out 1      state == COUNTING
//   done        out 1      state == DONE
//   count       out CNT_W  current count
//   rounds_left out RPT_W  rounds remaining after the current one
//   round_tick  out 1      1-cycle pulse after each non-final round wraps
//   aborted     out 1      1-cycle pulse after an accepted abort
module fsm_round_counter
   import fsm_pkg::*;
#(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned RPT_W      = 4,
   parameter bit          DONE_PULSE = DONE_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             abort,
   input  logic             ack,
   input  logic [CNT_W-1:0] term,
   input  logic [RPT_W-1:0] repeat_n,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic [RPT_W-1:0] rounds_left,
   output logic             round_tick,
   output logic             aborted
);

   state_t           state;
   logic [CNT_W-1:0] term_q;
   logic             at_term;
   logic             last_round;
   logic             cnt_clr;
   logic             cnt_en;

   assign last_round = (rounds_left == '0);

   // Counter control mirrors the FSM transition priorities below:
   // abort > wrap > increment; the final round's terminal value is held.
   always_comb begin
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = go & ~abort;
         end
         COUNTING: begin
            if (abort) begin
               cnt_clr = 1'b1;
            end else if (at_term) begin
               cnt_clr = ~last_round;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   fsm_cnt_core #(
      .W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .term    (term_q),
      .count   (count),
      .at_term (at_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         term_q      <= '0;
         rounds_left <= '0;
         round_tick  <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         round_tick <= 1'b0;
         aborted    <= 1'b0;
         case (state)
            IDLE: begin
               // go together with abort is treated as a cancelled start.
               if (go && !abort) begin
                  state       <= COUNTING;
                  term_q      <= term;
                  rounds_left <= repeat_n;
               end
            end
            COUNTING: begin
               if (abort) begin
                  state   <= IDLE;
                  aborted <= 1'b1;
               end else if (at_term) begin
                  if (last_round) begin
                     state <= DONE;
                  end else begin
                     rounds_left <= rounds_left - RPT_W'(1);
                     round_tick  <= 1'b1;
                  end
               end
            end
            DONE: begin
               // go is never looked at here, so go+ack only returns to IDLE.
               if (DONE_PULSE == DONE_ONESHOT) begin
                  state <= IDLE;
               end else if (abort) begin
                  state   <= IDLE;
                  aborted <= 1'b1;
               end else if (ack) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == COUNTING);
   assign done = (state == DONE);

endmodule

// File: tb/tb_fsm_round_counter.sv
// Directed self-checking bench for fsm_round_counter.
// u_dut  : held-done variant, driven by go.
// u_dutp : one-shot-done variant, driven by go_p; other inputs shared.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_fsm_round_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go = 1'b0;
   logic       go_p = 1'b0;
   logic       abort = 1'b0;
   logic       ack = 1'b0;
   logic [7:0] term = 8'd0;
   logic [3:0] repeat_n = 4'd0;

   logic       busy, done, round_tick, aborted;
   logic [7:0] count;
   logic [3:0] rounds_left;
   logic       busy_p, done_p, round_tick_p, aborted_p;
   logic [7:0] count_p;
   logic [3:0] rounds_left_p;

   logic [15:0] obs, obs_p;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   fsm_round_counter #(
      .CNT_W      (8),
      .RPT_W      (4),
      .DONE_PULSE (1'b0)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .abort       (abort),
      .ack         (ack),
      .term        (term),
      .repeat_n    (repeat_n),
      .busy        (busy),
      .done        (done),
      .count       (count),
      .rounds_left (rounds_left),
      .round_tick  (round_tick),
      .aborted     (aborted)
   );

   fsm_round_counter #(
      .CNT_W      (8),
      .RPT_W      (4),
      .DONE_PULSE (1'b1)
   ) u_dutp (
      .clk         (clk),
      .rst         (rst),
      .go          (go_p),
      .abort       (abort),
      .ack         (ack),
      .term        (term),
      .repeat_n    (repeat_n),
      .busy        (busy_p),
      .done        (done_p),
      .count       (count_p),
      .rounds_left (rounds_left_p),
      .round_tick  (round_tick_p),
      .aborted     (aborted_p)
   );

   assign obs   = {busy, done, count, rounds_left, round_tick, aborted};
   assign obs_p = {busy_p, done_p, count_p, rounds_left_p, round_tick_p, aborted_p};

   // Expected output vector: {busy, done, count, rounds_left, round_tick, aborted}
   function automatic logic [15:0] ev(input logic b, input logic d, input logic [7:0] c,
                                      input logic [3:0] r, input logic t, input logic a);
      return {b, d, c, r, t, a};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vectors++;
      if (obs !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL reset_hold got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
      rst = 1'b0;
      step();
      vectors++;
      if (obs_p !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL reset_oneshot got=%h exp=%h", obs_p, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_single_round();
      term = 8'd3; repeat_n = 4'd0; go = 1'b1;
      step();
      go = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (obs !== ev(1'b1, 1'b0, 8'(k), 4'd0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL single_count[%0d] got=%h exp=%h", k, obs, ev(1'b1, 1'b0, 8'(k), 4'd0, 1'b0, 1'b0));
         end
         step();
      end
      vectors++;
      if (obs !== ev(1'b0, 1'b1, 8'd3, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL single_done got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'd3, 4'd0, 1'b0, 1'b0));
      end
      step();
      vectors++;
      if (obs !== ev(1'b0, 1'b1, 8'd3, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL single_done_hold got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'd3, 4'd0, 1'b0, 1'b0));
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      vectors++;
      if (obs !== ev(1'b0, 1'b0, 8'd3, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL single_ack got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'd3, 4'd0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_multi_round();
      logic [15:0] exp_t [7];
      exp_t = '{ev(1'b1, 1'b0, 8'd0, 4'd2, 1'b0, 1'b0),
                ev(1'b1, 1'b0, 8'd1, 4'd2, 1'b0, 1'b0),
                ev(1'b1, 1'b0, 8'd0, 4'd1, 1'b1, 1'b0),
                ev(1'b1, 1'b0, 8'd1, 4'd1, 1'b0, 1'b0),
                ev(1'b1, 1'b0, 8'd0, 4'd0, 1'b1, 1'b0),
                ev(1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 1'b0),
                ev(1'b0, 1'b1, 8'd1, 4'd0, 1'b0, 1'b0)};
      term = 8'd1; repeat_n = 4'd2; go = 1'b1;
      step();
      go = 1'b0;
      // Changing the live inputs while busy must not disturb the latched run.
      term = 8'd7; repeat_n = 4'd5;
      for (int k = 0; k < 7; k++) begin
         vectors++;
         if (obs !== exp_t[k]) begin
            miscompares++;
            $display("FAIL multi_round[%0d] got=%h exp=%h", k, obs, exp_t[k]);
         end
         if (k < 6) step();
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_abort();
      term = 8'd5; repeat_n = 4'd0; go = 1'b1;
      step();
      go = 1'b0;
      step();
      step();
      vectors++;
      if (obs !== ev(1'b1, 1'b0, 8'd2, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL abort_pre got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'd2, 4'd0, 1'b0, 1'b0));
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      vectors++;
      if (obs !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1)) begin
         miscompares++;
         $display("FAIL abort_pulse got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1));
      end
      for (int k = 0; k < 4; k++) begin
         step();
         vectors++;
         if (obs !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL abort_after[%0d] got=%h exp=%h", k, obs, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic test_oneshot();
      term = 8'd0; repeat_n = 4'd0; go_p = 1'b1;
      step();
      go_p = 1'b0;
      vectors++;
      if (obs_p !== ev(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL oneshot_busy got=%h exp=%h", obs_p, ev(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
      ack = 1'b1;
      step();
      vectors++;
      if (obs_p !== ev(1'b0, 1'b1, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL oneshot_done got=%h exp=%h", obs_p, ev(1'b0, 1'b1, 8'd0, 4'd0, 1'b0, 1'b0));
      end
      step();
      ack = 1'b0;
      vectors++;
      if (obs_p !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL oneshot_drop got=%h exp=%h", obs_p, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
      // Abort during the one-shot DONE cycle: back to IDLE with no aborted pulse.
      go_p = 1'b1;
      step();
      go_p = 1'b0;
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      vectors++;
      if (obs_p !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL oneshot_abort got=%h exp=%h", obs_p, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_reset_mid_round();
      term = 8'd9; repeat_n = 4'd1; go = 1'b1;
      step();
      go = 1'b0;
      repeat (4) step();
      vectors++;
      if (obs !== ev(1'b1, 1'b0, 8'd4, 4'd1, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL rst_pre got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'd4, 4'd1, 1'b0, 1'b0));
      end
      rst = 1'b1; go = 1'b1; abort = 1'b1;
      step();
      rst = 1'b0; go = 1'b0; abort = 1'b0;
      vectors++;
      if (obs !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL rst_mid got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
      term = 8'd2; repeat_n = 4'd0; go = 1'b1;
      step();
      go = 1'b0;
      vectors++;
      if (obs !== ev(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL rst_restart got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
      repeat (3) step();
      vectors++;
      if (obs !== ev(1'b0, 1'b1, 8'd2, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL rst_restart_done got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'd2, 4'd0, 1'b0, 1'b0));
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_corners();
      // go with abort in IDLE: no start, no pulse, count holds 2.
      go = 1'b1; abort = 1'b1;
      step();
      go = 1'b0; abort = 1'b0;
      vectors++;
      if (obs !== ev(1'b0, 1'b0, 8'd2, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL go_abort_idle got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'd2, 4'd0, 1'b0, 1'b0));
      end
      // go with ack in DONE: return to IDLE without restarting.
      term = 8'd0; repeat_n = 4'd0; go = 1'b1;
      step();
      go = 1'b0;
      step();
      go = 1'b1; ack = 1'b1;
      step();
      go = 1'b0; ack = 1'b0;
      vectors++;
      if (obs !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL go_ack_done got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
      step();
      vectors++;
      if (obs !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL go_ack_norestart got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0));
      end
      // abort in held DONE pulses aborted.
      go = 1'b1;
      step();
      go = 1'b0;
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      vectors++;
      if (obs !== ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1)) begin
         miscompares++;
         $display("FAIL abort_done got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1));
      end
      // Full-range terminal: 256 counting cycles, no compare overflow.
      term = 8'hFF; repeat_n = 4'd0; go = 1'b1;
      step();
      go = 1'b0;
      repeat (255) step();
      vectors++;
      if (obs !== ev(1'b1, 1'b0, 8'hFF, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL ff_last got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'hFF, 4'd0, 1'b0, 1'b0));
      end
      step();
      vectors++;
      if (obs !== ev(1'b0, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL ff_done got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0));
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_round();
      test_multi_round();
      test_abort();
      test_oneshot();
      test_reset_mid_round();
      test_corners();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
